// File: rtl/twos_comp_serial_pkg.sv
// Shared types and constants for the bit-serial two's-complement +1 stage.
package twos_comp_serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  // The +1 of ~a + 1 enters as the initial carry into bit 0.
  localparam logic CARRY_IN = 1'b1;

endpackage : twos_comp_serial_pkg

// File: rtl/twos_comp_serial_half_adder_cell.sv
// One-bit half adder used to ripple the +1 carry through the serial stream.
module serial_half_adder_cell (
  input  logic a_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);

  // Sum and carry of a single bit plus the incoming carry.
  always_comb begin
    s_o  = a_i ^ c_i;
    co_o = a_i & c_i;
  end

endmodule : serial_half_adder_cell

// File: rtl/twos_comp_serial.sv
// Bit-serial +1 stage: turns the ones' complement ~a into -a = ~a + 1,
// LSB first, with valid/ready on both sides. Flags a = 0 (cout) and
// a = most-negative (ovf).
module twos_comp_serial
  import twos_comp_serial_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e             state_q;
  logic [WIDTH-1:0]   sr_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               msb_in_q;
  logic               cout_q;
  logic               ovf_q;
  logic               sum_d;
  logic               carry_d;

  serial_half_adder_cell u_cell (
    .a_i  (sr_q[0]),
    .c_i  (carry_q),
    .s_o  (sum_d),
    .co_o (carry_d)
  );

  // Control FSM, shift register, bit counter, carry and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      msb_in_q <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sr_q     <= din;
            msb_in_q <= din[WIDTH-1];
            carry_q  <= CARRY_IN;
            cnt_q    <= '0;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          sr_q    <= {sum_d, sr_q[WIDTH-1:1]};
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            // sum_d is the new MSB, so the flag is ready together with dout.
            state_q <= DONE;
            cout_q  <= carry_d;
            ovf_q   <= ~msb_in_q & sum_d;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          cout_q  <= 1'b0;
          ovf_q   <= 1'b0;
        end
      endcase
    end
  end

  // Handshake and result outputs decoded from held state; dout is masked
  // outside DONE so a partially shifted word is never visible.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    dout      = out_valid ? sr_q : '0;
    cout      = cout_q;
    ovf       = ovf_q;
  end

endmodule : twos_comp_serial
